// File: rtl/j1_uart_io_if.sv
// J1 I/O port bus between the CPU (master) and an I/O responder (slave).
// Strobes, address and write data flow to the responder; read data returns combinationally.
interface j1_uart_io_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (output io_rd, io_wr, io_addr, io_dout, input io_din);
    modport slave  (input io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/j1_uart_io.sv
// UART peripheral on the J1 I/O port: DATA/STATUS/DIVISOR window, TX/RX FIFOs, 8N1 framing.
// Latency: reads are combinational in the strobe cycle; TX starts the cycle after a push.
// Backpressure: none on the bus; full FIFOs drop bytes and set sticky flags. J1_UART_LOOPBACK_EN adds loopback.

// Small FIFO with combinational head; simultaneous push and pop keep the count.
// Latency: one cycle push-to-visible; pushes when full and pops when empty are ignored.
module j1_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_n_i,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge sys_clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end
endmodule

module j1_uart_io #(
    parameter logic [15:0] BASE_ADDR   = 16'hF000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    j1_uart_io_if.slave io,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        irq_o
);
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

    logic        sel;
    logic [1:0]  idx;
    logic        rd_data;
    logic        wr_data;
    logic        wr_stat;
    logic        wr_div;
    logic        unused_addr0;

    logic [15:0] divisor;
    logic [16:0] div_p1;
    logic [15:0] rx_half;
    logic        rx_ovr;
    logic        frm_err;
    logic        tx_ovf;
    logic        loop_bit;
    logic [15:0] status;

    logic        tx_full;
    logic        tx_fifo_empty;
    logic [7:0]  tx_head;
    logic        tx_pop;
    uart_st_t    tx_st;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shreg;
    logic        tx_line;

    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        rx_src;
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic        rx_prev;
    uart_st_t    rx_st;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shreg;
    logic        rx_stop_smp;
    logic        rx_push;
    logic        rx_drop;

    assign sel          = (io.io_addr[15:3] == BASE_ADDR[15:3]);
    assign idx          = io.io_addr[2:1];
    assign unused_addr0 = io.io_addr[0];
    assign rd_data      = io.io_rd && sel && (idx == REG_DATA);
    assign wr_data      = io.io_wr && sel && (idx == REG_DATA);
    assign wr_stat      = io.io_wr && sel && (idx == REG_STAT);
    assign wr_div       = io.io_wr && sel && (idx == REG_DIV);

    assign status = {7'd0, loop_bit, 2'd0, tx_ovf, frm_err, rx_ovr, !rx_empty,
                     tx_fifo_empty && (tx_st == S_IDLE), tx_full};

    always_comb begin
        io.io_din = 16'h0000;
        if (io.io_rd && sel) begin
            case (idx)
                REG_DATA: io.io_din = {8'h00, rx_empty ? 8'h00 : rx_head};
                REG_STAT: io.io_din = status;
                REG_DIV:  io.io_din = divisor;
                default:  io.io_din = 16'h0000;
            endcase
        end
    end

    assign irq_o = !rx_empty;

    // Sticky flags: a set event in the same cycle as a clear write keeps the flag.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            divisor <= DEFAULT_DIV;
            rx_ovr  <= 1'b0;
            frm_err <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            if (wr_div) divisor <= io.io_dout;
            if (rx_drop)                          rx_ovr  <= 1'b1;
            else if (wr_stat && io.io_dout[3])    rx_ovr  <= 1'b0;
            if (rx_stop_smp && !rx_s)             frm_err <= 1'b1;
            else if (wr_stat && io.io_dout[4])    frm_err <= 1'b0;
            if (wr_data && tx_full)               tx_ovf  <= 1'b1;
            else if (wr_stat && io.io_dout[5])    tx_ovf  <= 1'b0;
        end
    end

`ifdef J1_UART_LOOPBACK_EN
    logic loop_en;
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i)  loop_en <= 1'b0;
        else if (wr_stat)  loop_en <= io.io_dout[8];
    end
    assign loop_bit   = loop_en;
    assign rx_src     = loop_en ? tx_line : uart_rxd_i;
    assign uart_txd_o = loop_en ? 1'b1 : tx_line;
`else
    assign loop_bit   = 1'b0;
    assign rx_src     = uart_rxd_i;
    assign uart_txd_o = tx_line;
`endif

    j1_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .wr_vld      (wr_data),
        .wr_dat      (io.io_dout[7:0]),
        .rd_rdy      (tx_pop),
        .rd_dat      (tx_head),
        .full        (tx_full),
        .empty       (tx_fifo_empty)
    );

    // A new frame is fetched from IDLE or straight out of the last STOP clock.
    assign tx_pop = !tx_fifo_empty &&
                    ((tx_st == S_IDLE) || ((tx_st == S_STOP) && (tx_cnt == 16'd0)));

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            tx_st    <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shreg <= 8'd0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_st)
                S_IDLE: if (tx_pop) begin
                    tx_st    <= S_START;
                    tx_shreg <= tx_head;
                    tx_cnt   <= divisor;
                    tx_line  <= 1'b0;
                end
                S_START: if (tx_cnt == 16'd0) begin
                    tx_st    <= S_DATA;
                    tx_cnt   <= divisor;
                    tx_bit   <= 3'd0;
                    tx_line  <= tx_shreg[0];
                    tx_shreg <= {1'b0, tx_shreg[7:1]};
                end else tx_cnt <= tx_cnt - 16'd1;
                S_DATA: if (tx_cnt == 16'd0) begin
                    tx_cnt <= divisor;
                    if (tx_bit == 3'd7) begin
                        tx_st   <= S_STOP;
                        tx_line <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_line  <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                S_STOP: if (tx_cnt == 16'd0) begin
                    if (tx_pop) begin
                        tx_st    <= S_START;
                        tx_shreg <= tx_head;
                        tx_cnt   <= divisor;
                        tx_line  <= 1'b0;
                    end else tx_st <= S_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_st <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_src};
            rx_prev <= rx_sync[1];
        end
    end
    assign rx_s = rx_sync[1];

    // Start sample lands (DIVISOR+1)/2 clocks after the detected edge; the counter runs to zero inclusive.
    assign div_p1  = {1'b0, divisor} + 17'd1;
    assign rx_half = (div_p1[16:1] == 16'd0) ? 16'd0 : div_p1[16:1] - 16'd1;

    assign rx_stop_smp = (rx_st == S_STOP) && (rx_cnt == 16'd0);
    assign rx_push     = rx_stop_smp && !rx_full;
    assign rx_drop     = rx_stop_smp && rx_full;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            rx_st    <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shreg <= 8'd0;
        end else begin
            case (rx_st)
                S_IDLE: if (rx_prev && !rx_s) begin
                    rx_st  <= S_START;
                    rx_cnt <= rx_half;
                end
                S_START: if (rx_cnt == 16'd0) begin
                    if (rx_s) rx_st <= S_IDLE;
                    else begin
                        rx_st  <= S_DATA;
                        rx_cnt <= divisor;
                        rx_bit <= 3'd0;
                    end
                end else rx_cnt <= rx_cnt - 16'd1;
                S_DATA: if (rx_cnt == 16'd0) begin
                    rx_shreg <= {rx_s, rx_shreg[7:1]};
                    rx_cnt   <= divisor;
                    if (rx_bit == 3'd7) rx_st  <= S_STOP;
                    else                rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_STOP: if (rx_cnt == 16'd0) rx_st <= S_IDLE;
                        else                 rx_cnt <= rx_cnt - 16'd1;
                default: rx_st <= S_IDLE;
            endcase
        end
    end

    j1_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .wr_vld      (rx_push),
        .wr_dat      (rx_shreg),
        .rd_rdy      (rd_data),
        .rd_dat      (rx_head),
        .full        (rx_full),
        .empty       (rx_empty)
    );
endmodule

// File: tb/tb_j1_uart_io.sv
// Directed bench for j1_uart_io: register decode, TX framing, FIFOs, RX errors, optional loopback.
module tb_j1_uart_io;
    logic sys_clk_i;
    logic sys_rst_n_i;
    logic uart_rxd_i;
    logic uart_txd_o;
    logic irq_o;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    j1_uart_io_if bus();

    j1_uart_io #(.BASE_ADDR(16'hF000), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .io          (bus),
        .uart_rxd_i  (uart_rxd_i),
        .uart_txd_o  (uart_txd_o),
        .irq_o       (irq_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] dat);
        bus.io_addr = addr;
        bus.io_dout = dat;
        bus.io_wr   = 1'b1;
        @(negedge sys_clk_i);
        bus.io_wr   = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        bus.io_addr = addr;
        bus.io_rd   = 1'b1;
        #1;
        check(tag, bus.io_din, exp);
        @(negedge sys_clk_i);
        bus.io_rd   = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        sys_rst_n_i = 1'b1;
        @(negedge sys_clk_i);
    endtask

    // Expects the start bit to appear at the next negedge; 4 clocks per bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic expb;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      expb = 1'b0;
            else if (i == 9) expb = 1'b1;
            else             expb = b[i-1];
            repeat (4) begin
                @(negedge sys_clk_i);
                check(tag, {15'd0, uart_txd_o}, {15'd0, expb});
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rxd_i = 1'b0;
        repeat (4) @(negedge sys_clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rxd_i = b[i];
            repeat (4) @(negedge sys_clk_i);
        end
        uart_rxd_i = stop_bit;
        repeat (4) @(negedge sys_clk_i);
        uart_rxd_i = 1'b1;
    endtask

    initial begin
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        bus.io_addr = 16'h0000;
        bus.io_dout = 16'h0000;
        uart_rxd_i  = 1'b1;
        sys_rst_n_i = 1'b0;
        do_reset();

        // Reset values and decode
        check("rst_irq", {15'd0, irq_o}, 16'd0);
        check("rst_txd", {15'd0, uart_txd_o}, 16'd1);
        check("rst_din_idle", bus.io_din, 16'h0000);
        cpu_rd(16'hF002, 16'h0002, "rst_status");
        cpu_rd(16'hF004, 16'd433,  "rst_divisor");
        cpu_rd(16'hF003, 16'h0002, "addr0_ignored");
        cpu_rd(16'hF006, 16'h0000, "reserved_rd");
        cpu_rd(16'hF000, 16'h0000, "data_empty");
        cpu_rd(16'hE002, 16'h0000, "unselected_lo");
        cpu_rd(16'hF00A, 16'h0000, "unselected_next");

        // TX framing
        cpu_wr(16'hF004, 16'd3);
        cpu_rd(16'hF004, 16'd3, "divisor_wr");
        cpu_wr(16'hF000, 16'h00A5);
        check_frame(8'hA5, "tx_a5");
        @(negedge sys_clk_i);
        cpu_rd(16'hF002, 16'h0002, "tx_empty_after");

        // TX back-to-back, five bytes into a four-deep FIFO behind the shifter
        fork
            begin
                cpu_wr(16'hF000, 16'h0011);
                cpu_wr(16'hF000, 16'h0022);
                cpu_wr(16'hF000, 16'h0033);
                cpu_wr(16'hF000, 16'h0044);
                cpu_wr(16'hF000, 16'h0055);
            end
            begin
                @(negedge sys_clk_i);
                check_frame(8'h11, "b2b_11");
                check_frame(8'h22, "b2b_22");
                check_frame(8'h33, "b2b_33");
                check_frame(8'h44, "b2b_44");
                check_frame(8'h55, "b2b_55");
            end
        join
        @(negedge sys_clk_i);
        cpu_rd(16'hF002, 16'h0002, "b2b_no_ovf");

        // Slow shifter: fill FIFO then overflow
        cpu_wr(16'hF004, 16'd1000);
        cpu_wr(16'hF000, 16'h0001);
        cpu_wr(16'hF000, 16'h0002);
        cpu_wr(16'hF000, 16'h0003);
        cpu_wr(16'hF000, 16'h0004);
        cpu_wr(16'hF000, 16'h0005);
        cpu_rd(16'hF002, 16'h0001, "tx_full");
        cpu_wr(16'hF000, 16'h0006);
        cpu_rd(16'hF002, 16'h0021, "tx_ovf_set");
        cpu_wr(16'hF002, 16'h0020);
        cpu_rd(16'hF002, 16'h0001, "tx_ovf_clr");
        check("tx_start_low", {15'd0, uart_txd_o}, 16'd0);

        // Reset mid-frame
        sys_rst_n_i = 1'b0;
        #1;
        check("rst_midframe_txd", {15'd0, uart_txd_o}, 16'd1);
        repeat (2) @(negedge sys_clk_i);
        sys_rst_n_i = 1'b1;
        @(negedge sys_clk_i);
        cpu_rd(16'hF002, 16'h0002, "rst_midframe_stat");
        cpu_rd(16'hF004, 16'd433,  "rst_midframe_div");

        // RX and pop
        cpu_wr(16'hF004, 16'd3);
        send_rx(8'h3C, 1'b1);
        repeat (3) @(negedge sys_clk_i);
        check("rx_irq", {15'd0, irq_o}, 16'd1);
        cpu_rd(16'hF002, 16'h0006, "rx_avail");
        cpu_rd(16'hF000, 16'h003C, "rx_data");
        check("rx_irq_clr", {15'd0, irq_o}, 16'd0);
        cpu_rd(16'hF000, 16'h0000, "rx_popped");

        // RX glitch
        uart_rxd_i = 1'b0;
        @(negedge sys_clk_i);
        uart_rxd_i = 1'b1;
        repeat (20) @(negedge sys_clk_i);
        check("glitch_irq", {15'd0, irq_o}, 16'd0);
        cpu_rd(16'hF002, 16'h0002, "glitch_stat");

        // Framing error
        send_rx(8'h81, 1'b0);
        repeat (3) @(negedge sys_clk_i);
        cpu_rd(16'hF002, 16'h0016, "frm_err_stat");
        cpu_rd(16'hF000, 16'h0081, "frm_err_data");
        cpu_wr(16'hF002, 16'h0010);
        cpu_rd(16'hF002, 16'h0002, "frm_err_clr");

        // RX overrun
        send_rx(8'h11, 1'b1); repeat (2) @(negedge sys_clk_i);
        send_rx(8'h22, 1'b1); repeat (2) @(negedge sys_clk_i);
        send_rx(8'h33, 1'b1); repeat (2) @(negedge sys_clk_i);
        send_rx(8'h44, 1'b1); repeat (2) @(negedge sys_clk_i);
        send_rx(8'h55, 1'b1); repeat (3) @(negedge sys_clk_i);
        cpu_rd(16'hF002, 16'h000E, "rx_ovr_stat");
        cpu_rd(16'hF000, 16'h0011, "rx_ovr_b0");
        cpu_rd(16'hF000, 16'h0022, "rx_ovr_b1");
        cpu_rd(16'hF000, 16'h0033, "rx_ovr_b2");
        cpu_rd(16'hF000, 16'h0044, "rx_ovr_b3");
        cpu_rd(16'hF000, 16'h0000, "rx_ovr_drained");
        check("rx_ovr_irq", {15'd0, irq_o}, 16'd0);

`ifdef J1_UART_LOOPBACK_EN
        begin
            logic txd_dropped;
            txd_dropped = 1'b0;
            cpu_wr(16'hF002, 16'h0100);
            cpu_rd(16'hF002, 16'h010A, "loop_bit");
            cpu_wr(16'hF000, 16'h005A);
            repeat (50) begin
                @(negedge sys_clk_i);
                if (uart_txd_o !== 1'b1) txd_dropped = 1'b1;
            end
            check("loop_txd_high", {15'd0, txd_dropped}, 16'd0);
            cpu_rd(16'hF000, 16'h005A, "loop_data");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
